// File: rtl/bp_axi_mem_window_if.sv
// AXI4 bus bundle for bp_axi_mem_window: master drives requests and W data, slave drives B/R responses.
interface bp_axi_mem_window_if #(
   parameter int unsigned ADDR_WIDTH_P = 64,
   parameter int unsigned DATA_WIDTH_P = 128,
   parameter int unsigned ID_WIDTH_P   = 4
);
   logic [ADDR_WIDTH_P-1:0]   awaddr;
   logic [ID_WIDTH_P-1:0]     awid;
   logic [7:0]                awlen;
   logic [2:0]                awsize;
   logic [1:0]                awburst;
   logic                      awlock;
   logic [3:0]                awcache;
   logic [2:0]                awprot;
   logic [3:0]                awqos;
   logic [3:0]                awregion;
   logic                      awvalid;
   logic                      awready;

   logic [DATA_WIDTH_P-1:0]   wdata;
   logic [DATA_WIDTH_P/8-1:0] wstrb;
   logic                      wlast;
   logic                      wvalid;
   logic                      wready;

   logic [ID_WIDTH_P-1:0]     bid;
   logic [1:0]                bresp;
   logic                      bvalid;
   logic                      bready;

   logic [ADDR_WIDTH_P-1:0]   araddr;
   logic [ID_WIDTH_P-1:0]     arid;
   logic [7:0]                arlen;
   logic [2:0]                arsize;
   logic [1:0]                arburst;
   logic                      arlock;
   logic [3:0]                arcache;
   logic [2:0]                arprot;
   logic [3:0]                arqos;
   logic [3:0]                arregion;
   logic                      arvalid;
   logic                      arready;

   logic [DATA_WIDTH_P-1:0]   rdata;
   logic [ID_WIDTH_P-1:0]     rid;
   logic [1:0]                rresp;
   logic                      rlast;
   logic                      rvalid;
   logic                      rready;

   modport master (
      output awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
      input  arready,
      input  rdata, rid, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
      output arready,
      output rdata, rid, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/bp_axi_mem_window.sv
// DRAM address window between the BlackParrot memory AXI manager and the DRAM controller.
// Out-of-window requests are absorbed and answered with DECERR. Optional macro AXI_MEM_WINDOW_ERR_CNT_EN adds error counters.
module bp_axi_mem_window #(
   parameter int unsigned ADDR_WIDTH_P = 64,
   parameter int unsigned DATA_WIDTH_P = 128,
   parameter int unsigned ID_WIDTH_P   = 4,
   parameter logic [63:0] BASE_ADDR_P  = 64'h8000_0000,
   parameter logic [63:0] SIZE_P       = 64'h4000_0000
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   bp_axi_mem_window_if.slave        s_axi,
   bp_axi_mem_window_if.master       m_axi
`ifdef AXI_MEM_WINDOW_ERR_CNT_EN
   ,
   output logic [15:0]               err_rd_cnt_o,
   output logic [15:0]               err_wr_cnt_o
`endif
);
   localparam int unsigned EXT_W = ADDR_WIDTH_P + 9;
   localparam logic [EXT_W-1:0]        BASE_EXT  = EXT_W'(BASE_ADDR_P);
   localparam logic [EXT_W-1:0]        LIMIT_EXT = EXT_W'(BASE_ADDR_P) + EXT_W'(SIZE_P) - EXT_W'(1);
   localparam logic [ADDR_WIDTH_P-1:0] BASE_A    = ADDR_WIDTH_P'(BASE_ADDR_P);

   typedef enum logic [2:0] {W_IDLE, W_PASS, W_DRAIN, W_BPASS, W_BERR} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_PASS, R_ERR} r_state_e;

   w_state_e                r_wstate;
   r_state_e                r_rstate;
   logic [ID_WIDTH_P-1:0]   r_wid;
   logic [ID_WIDTH_P-1:0]   r_rid;
   logic [7:0]              r_rlen;
   logic [7:0]              r_rcnt;

   logic w_aw_in, w_ar_in, w_aw_acc, w_ar_acc;

   // Widened by 9 bits so the burst end never wraps past the top of the address space.
   function automatic logic f_in_window(input logic [ADDR_WIDTH_P-1:0] addr,
                                        input logic [7:0] len, input logic [2:0] size);
      logic [EXT_W-1:0] w_last;
      w_last = EXT_W'(addr) + (EXT_W'({1'b0, len} + 9'd1) << size) - EXT_W'(1);
      return (EXT_W'(addr) >= BASE_EXT) && (w_last <= LIMIT_EXT);
   endfunction

   assign w_aw_in  = f_in_window(s_axi.awaddr, s_axi.awlen, s_axi.awsize);
   assign w_ar_in  = f_in_window(s_axi.araddr, s_axi.arlen, s_axi.arsize);
   assign w_aw_acc = s_axi.awvalid & s_axi.awready;
   assign w_ar_acc = s_axi.arvalid & s_axi.arready;

   always_comb begin
      m_axi.awaddr   = s_axi.awaddr - BASE_A;
      m_axi.awid     = s_axi.awid;
      m_axi.awlen    = s_axi.awlen;
      m_axi.awsize   = s_axi.awsize;
      m_axi.awburst  = s_axi.awburst;
      m_axi.awlock   = s_axi.awlock;
      m_axi.awcache  = s_axi.awcache;
      m_axi.awprot   = s_axi.awprot;
      m_axi.awqos    = s_axi.awqos;
      m_axi.awregion = s_axi.awregion;
      m_axi.awvalid  = 1'b0;
      s_axi.awready  = 1'b0;
      m_axi.wdata    = s_axi.wdata;
      m_axi.wstrb    = s_axi.wstrb;
      m_axi.wlast    = s_axi.wlast;
      m_axi.wvalid   = 1'b0;
      s_axi.wready   = 1'b0;
      s_axi.bid      = m_axi.bid;
      s_axi.bresp    = m_axi.bresp;
      s_axi.bvalid   = 1'b0;
      m_axi.bready   = 1'b0;
      case (r_wstate)
         // Idle outputs are gated by reset so every handshake line is low while reset is held.
         W_IDLE: if (!reset_i) begin
            m_axi.awvalid = s_axi.awvalid & w_aw_in;
            s_axi.awready = w_aw_in ? m_axi.awready : 1'b1;
         end
         W_PASS: begin
            m_axi.wvalid = s_axi.wvalid;
            s_axi.wready = m_axi.wready;
         end
         W_DRAIN: s_axi.wready = 1'b1;
         W_BPASS: begin
            s_axi.bvalid = m_axi.bvalid;
            m_axi.bready = s_axi.bready;
         end
         W_BERR: begin
            s_axi.bvalid = 1'b1;
            s_axi.bresp  = 2'b11;
            s_axi.bid    = r_wid;
         end
         default: ;
      endcase
   end

   always_comb begin
      m_axi.araddr   = s_axi.araddr - BASE_A;
      m_axi.arid     = s_axi.arid;
      m_axi.arlen    = s_axi.arlen;
      m_axi.arsize   = s_axi.arsize;
      m_axi.arburst  = s_axi.arburst;
      m_axi.arlock   = s_axi.arlock;
      m_axi.arcache  = s_axi.arcache;
      m_axi.arprot   = s_axi.arprot;
      m_axi.arqos    = s_axi.arqos;
      m_axi.arregion = s_axi.arregion;
      m_axi.arvalid  = 1'b0;
      s_axi.arready  = 1'b0;
      s_axi.rdata    = m_axi.rdata;
      s_axi.rid      = m_axi.rid;
      s_axi.rresp    = m_axi.rresp;
      s_axi.rlast    = m_axi.rlast;
      s_axi.rvalid   = 1'b0;
      m_axi.rready   = 1'b0;
      case (r_rstate)
         R_IDLE: if (!reset_i) begin
            m_axi.arvalid = s_axi.arvalid & w_ar_in;
            s_axi.arready = w_ar_in ? m_axi.arready : 1'b1;
         end
         R_PASS: begin
            s_axi.rvalid = m_axi.rvalid;
            m_axi.rready = s_axi.rready;
         end
         R_ERR: begin
            s_axi.rvalid = 1'b1;
            s_axi.rdata  = {DATA_WIDTH_P{1'b0}};
            s_axi.rresp  = 2'b11;
            s_axi.rid    = r_rid;
            s_axi.rlast  = (r_rcnt == r_rlen);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_wstate <= W_IDLE;
         r_wid    <= '0;
      end else begin
         case (r_wstate)
            W_IDLE: if (w_aw_acc) begin
               if (w_aw_in) begin
                  r_wstate <= W_PASS;
               end else begin
                  r_wid    <= s_axi.awid;
                  r_wstate <= W_DRAIN;
               end
            end
            W_PASS:  if (s_axi.wvalid && m_axi.wready && s_axi.wlast) r_wstate <= W_BPASS;
            W_DRAIN: if (s_axi.wvalid && s_axi.wlast) r_wstate <= W_BERR;
            W_BPASS: if (m_axi.bvalid && s_axi.bready) r_wstate <= W_IDLE;
            W_BERR:  if (s_axi.bready) r_wstate <= W_IDLE;
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_rstate <= R_IDLE;
         r_rid    <= '0;
         r_rlen   <= '0;
         r_rcnt   <= '0;
      end else begin
         case (r_rstate)
            R_IDLE: if (w_ar_acc) begin
               if (w_ar_in) begin
                  r_rstate <= R_PASS;
               end else begin
                  r_rid    <= s_axi.arid;
                  r_rlen   <= s_axi.arlen;
                  r_rcnt   <= '0;
                  r_rstate <= R_ERR;
               end
            end
            R_PASS: if (m_axi.rvalid && s_axi.rready && m_axi.rlast) r_rstate <= R_IDLE;
            R_ERR: if (s_axi.rready) begin
               if (r_rcnt == r_rlen) r_rstate <= R_IDLE;
               else                  r_rcnt   <= r_rcnt + 8'd1;
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

`ifdef AXI_MEM_WINDOW_ERR_CNT_EN
   logic [15:0] r_err_rd_cnt;
   logic [15:0] r_err_wr_cnt;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_err_rd_cnt <= '0;
         r_err_wr_cnt <= '0;
      end else begin
         if (w_ar_acc && !w_ar_in && r_err_rd_cnt != '1) r_err_rd_cnt <= r_err_rd_cnt + 16'd1;
         if (w_aw_acc && !w_aw_in && r_err_wr_cnt != '1) r_err_wr_cnt <= r_err_wr_cnt + 16'd1;
      end
   end

   assign err_rd_cnt_o = r_err_rd_cnt;
   assign err_wr_cnt_o = r_err_wr_cnt;
`endif
endmodule

// File: tb/tb_bp_axi_mem_window.sv
// Self-checking bench for bp_axi_mem_window; define AXI_MEM_WINDOW_ERR_CNT_EN to also check the error counters.
module tb_bp_axi_mem_window;
   localparam logic [63:0] BASE = 64'h8000_0000;
   localparam logic [63:0] SIZE = 64'h4000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned exp_rd_err = 0;
   int unsigned exp_wr_err = 0;

   always #5 clk = ~clk;

   bp_axi_mem_window_if #(.ADDR_WIDTH_P(64), .DATA_WIDTH_P(128), .ID_WIDTH_P(4)) s_if ();
   bp_axi_mem_window_if #(.ADDR_WIDTH_P(64), .DATA_WIDTH_P(128), .ID_WIDTH_P(4)) m_if ();

`ifdef AXI_MEM_WINDOW_ERR_CNT_EN
   logic [15:0] err_rd_cnt;
   logic [15:0] err_wr_cnt;
`endif

   bp_axi_mem_window #(
      .ADDR_WIDTH_P(64), .DATA_WIDTH_P(128), .ID_WIDTH_P(4),
      .BASE_ADDR_P(BASE), .SIZE_P(SIZE)
   ) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .s_axi   (s_if),
      .m_axi   (m_if)
`ifdef AXI_MEM_WINDOW_ERR_CNT_EN
      ,
      .err_rd_cnt_o (err_rd_cnt),
      .err_wr_cnt_o (err_wr_cnt)
`endif
   );

   // Reference rule: the whole burst [addr, addr + (len+1)*2^size - 1] must lie inside [BASE, BASE+SIZE-1].
   function automatic bit in_win(logic [63:0] addr, int unsigned len, int unsigned size);
      logic [127:0] first, last;
      first = {64'd0, addr};
      last  = first + 128'((len + 1) * (1 << size)) - 128'd1;
      return (first >= {64'd0, BASE}) && (last <= {64'd0, BASE} + {64'd0, SIZE} - 128'd1);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_cnt;
`ifdef AXI_MEM_WINDOW_ERR_CNT_EN
      chk("err_rd_cnt", {112'd0, err_rd_cnt}, 128'(exp_rd_err));
      chk("err_wr_cnt", {112'd0, err_wr_cnt}, 128'(exp_wr_err));
`endif
   endtask

   task automatic clear_inputs;
      s_if.awaddr = '0; s_if.awid = '0; s_if.awlen = '0; s_if.awsize = '0; s_if.awburst = 2'b01;
      s_if.awlock = 1'b0; s_if.awcache = '0; s_if.awprot = '0; s_if.awqos = '0; s_if.awregion = '0;
      s_if.awvalid = 1'b0; s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = 1'b0; s_if.wvalid = 1'b0;
      s_if.bready = 1'b0;
      s_if.araddr = '0; s_if.arid = '0; s_if.arlen = '0; s_if.arsize = '0; s_if.arburst = 2'b01;
      s_if.arlock = 1'b0; s_if.arcache = '0; s_if.arprot = '0; s_if.arqos = '0; s_if.arregion = '0;
      s_if.arvalid = 1'b0; s_if.rready = 1'b0;
      m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.bid = '0; m_if.bresp = '0; m_if.bvalid = 1'b0;
      m_if.arready = 1'b0; m_if.rdata = '0; m_if.rid = '0; m_if.rresp = '0; m_if.rlast = 1'b0;
      m_if.rvalid = 1'b0;
   endtask

   task automatic chk_all_quiet(input string tag);
      chk({tag, "_s_awready"}, s_if.awready, 0);
      chk({tag, "_s_arready"}, s_if.arready, 0);
      chk({tag, "_s_wready"},  s_if.wready,  0);
      chk({tag, "_s_bvalid"},  s_if.bvalid,  0);
      chk({tag, "_s_rvalid"},  s_if.rvalid,  0);
      chk({tag, "_m_awvalid"}, m_if.awvalid, 0);
      chk({tag, "_m_arvalid"}, m_if.arvalid, 0);
      chk({tag, "_m_wvalid"},  m_if.wvalid,  0);
      chk({tag, "_m_bready"},  m_if.bready,  0);
      chk({tag, "_m_rready"},  m_if.rready,  0);
   endtask

   task automatic do_read(input logic [63:0] addr, input int unsigned len, input int unsigned size,
                          input logic [3:0] id, input int unsigned stall);
      bit           win;
      logic [127:0] d;
      logic [3:0]   qos;
      win = in_win(addr, len, size);
      qos = 4'($urandom);
      s_if.araddr = addr; s_if.arlen = len[7:0]; s_if.arsize = size[2:0]; s_if.arid = id;
      s_if.arqos = qos; s_if.arvalid = 1'b1; m_if.arready = 1'b1;
      settle;
      chk("ar_s_ready", s_if.arready, 1);
      chk("ar_m_valid", m_if.arvalid, win);
      if (win) begin
         chk("ar_m_addr", m_if.araddr, addr - BASE);
         chk("ar_m_len",  m_if.arlen, len);
         chk("ar_m_id",   m_if.arid, id);
         chk("ar_m_qos",  m_if.arqos, qos);
      end
      tick;
      s_if.arvalid = 1'b0; m_if.arready = 1'b0;
      if (!win && exp_rd_err < 16'hFFFF) exp_rd_err++;
      for (int unsigned b = 0; b <= len; b++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         if (win) begin
            m_if.rvalid = 1'b1; m_if.rdata = d; m_if.rid = id; m_if.rresp = 2'b00;
            m_if.rlast = (b == len);
         end
         s_if.rready = 1'b0;
         for (int unsigned k = 0; k < stall; k++) begin
            settle;
            chk("r_hold_valid", s_if.rvalid, 1);
            chk("r_hold_last",  s_if.rlast, b == len);
            tick;
         end
         s_if.rready = 1'b1;
         settle;
         chk("r_valid",    s_if.rvalid, 1);
         chk("r_data",     s_if.rdata, win ? d : 128'd0);
         chk("r_resp",     s_if.rresp, win ? 2'b00 : 2'b11);
         chk("r_id",       s_if.rid, id);
         chk("r_last",     s_if.rlast, b == len);
         chk("r_m_rready", m_if.rready, win);
         tick;
      end
      s_if.rready = 1'b0; m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
      settle;
      chk("r_done", s_if.rvalid, 0);
   endtask

   task automatic do_write(input logic [63:0] addr, input int unsigned len, input int unsigned size,
                           input logic [3:0] id, input int unsigned stall);
      bit           win;
      logic [127:0] d;
      logic [15:0]  st;
      logic [1:0]   br;
      logic [3:0]   cache;
      win   = in_win(addr, len, size);
      cache = 4'($urandom);
      s_if.awaddr = addr; s_if.awlen = len[7:0]; s_if.awsize = size[2:0]; s_if.awid = id;
      s_if.awcache = cache; s_if.awvalid = 1'b1; m_if.awready = 1'b1;
      settle;
      chk("aw_s_ready", s_if.awready, 1);
      chk("aw_m_valid", m_if.awvalid, win);
      if (win) begin
         chk("aw_m_addr",  m_if.awaddr, addr - BASE);
         chk("aw_m_cache", m_if.awcache, cache);
      end
      tick;
      s_if.awvalid = 1'b0; m_if.awready = 1'b0;
      if (!win && exp_wr_err < 16'hFFFF) exp_wr_err++;
      for (int unsigned b = 0; b <= len; b++) begin
         d  = {$urandom, $urandom, $urandom, $urandom};
         st = 16'($urandom);
         s_if.wvalid = 1'b1; s_if.wdata = d; s_if.wstrb = st; s_if.wlast = (b == len);
         m_if.wready = 1'b1;
         settle;
         chk("w_s_ready", s_if.wready, 1);
         chk("w_m_valid", m_if.wvalid, win);
         if (win) begin
            chk("w_m_data", m_if.wdata, d);
            chk("w_m_strb", m_if.wstrb, st);
            chk("w_m_last", m_if.wlast, b == len);
         end
         tick;
      end
      s_if.wvalid = 1'b0; s_if.wlast = 1'b0; m_if.wready = 1'b0;
      br = $urandom_range(0, 1) ? 2'b10 : 2'b00;
      if (win) begin
         m_if.bvalid = 1'b1; m_if.bid = id; m_if.bresp = br;
      end
      s_if.bready = 1'b0;
      for (int unsigned k = 0; k < stall; k++) begin
         settle;
         chk("b_hold_valid", s_if.bvalid, 1);
         tick;
      end
      s_if.bready = 1'b1;
      settle;
      chk("b_valid",    s_if.bvalid, 1);
      chk("b_resp",     s_if.bresp, win ? br : 2'b11);
      chk("b_id",       s_if.bid, id);
      chk("b_m_bready", m_if.bready, win);
      tick;
      s_if.bready = 1'b0; m_if.bvalid = 1'b0;
      settle;
      chk("b_done", s_if.bvalid, 0);
   endtask

   initial begin
      logic [127:0] d1, d2;
      logic [63:0]  addr;
      int unsigned  cat, len, size;
      logic [3:0]   id;

      // Reset with request activity on every input: nothing may handshake.
      clear_inputs();
      s_if.awvalid = 1'b1; s_if.awaddr = 64'h1000; s_if.arvalid = 1'b1; s_if.araddr = 64'h1000;
      s_if.wvalid = 1'b1; m_if.bvalid = 1'b1; m_if.rvalid = 1'b1; s_if.rready = 1'b1; s_if.bready = 1'b1;
      repeat (2) tick();
      chk_all_quiet("reset");
      chk_cnt();
      clear_inputs();
      rst = 1'b0;
      tick();

      // In-window read, remapped to 0x40 in the same cycle, 4 forwarded beats.
      do_read(64'h8000_0040, 3, 4, 4'h5, 0);
      // Out-of-window write drained with DECERR.
      do_write(64'h0000_1000, 1, 4, 4'hA, 0);
      chk_cnt();
      // Read straddling the window end, with rready held low for 5 cycles before each beat.
      do_read(64'hBFFF_FFF0, 1, 4, 4'h3, 5);
      chk_cnt();
      // Largest burst produces 256 error beats.
      do_read(64'h0000_0000, 255, 0, 4'h7, 0);
      // Exact window edges.
      do_read(BASE + SIZE - 64'd32, 1, 4, 4'h2, 1);
      do_write(BASE + SIZE - 64'd16, 0, 4, 4'h4, 2);
      do_read(BASE - 64'd16, 0, 4, 4'h6, 0);
      do_write(BASE, 0, 4, 4'h8, 0);
      chk_cnt();

      // Concurrent in-window AW and AR.
      s_if.awaddr = BASE + 64'h100; s_if.awlen = 8'd0; s_if.awsize = 3'd4; s_if.awid = 4'h1; s_if.awvalid = 1'b1;
      s_if.araddr = BASE + 64'h200; s_if.arlen = 8'd0; s_if.arsize = 3'd4; s_if.arid = 4'h2; s_if.arvalid = 1'b1;
      m_if.awready = 1'b1; m_if.arready = 1'b1;
      settle();
      chk("cc_aw_ready", s_if.awready, 1);
      chk("cc_ar_ready", s_if.arready, 1);
      chk("cc_m_awaddr", m_if.awaddr, 64'h100);
      chk("cc_m_araddr", m_if.araddr, 64'h200);
      tick();
      s_if.awvalid = 1'b0; s_if.arvalid = 1'b0; m_if.awready = 1'b0; m_if.arready = 1'b0;
      d1 = {$urandom, $urandom, $urandom, $urandom};
      d2 = {$urandom, $urandom, $urandom, $urandom};
      s_if.wvalid = 1'b1; s_if.wdata = d1; s_if.wlast = 1'b1; m_if.wready = 1'b1;
      m_if.rvalid = 1'b1; m_if.rdata = d2; m_if.rlast = 1'b1; m_if.rid = 4'h2; s_if.rready = 1'b1;
      settle();
      chk("cc_m_wvalid", m_if.wvalid, 1);
      chk("cc_m_wdata",  m_if.wdata, d1);
      chk("cc_s_rvalid", s_if.rvalid, 1);
      chk("cc_s_rdata",  s_if.rdata, d2);
      chk("cc_s_rlast",  s_if.rlast, 1);
      tick();
      s_if.wvalid = 1'b0; s_if.wlast = 1'b0; m_if.wready = 1'b0;
      m_if.rvalid = 1'b0; m_if.rlast = 1'b0; s_if.rready = 1'b0;
      m_if.bvalid = 1'b1; m_if.bid = 4'h1; m_if.bresp = 2'b00; s_if.bready = 1'b1;
      settle();
      chk("cc_s_bvalid", s_if.bvalid, 1);
      chk("cc_s_bid",    s_if.bid, 4'h1);
      chk("cc_r_done",   s_if.rvalid, 0);
      tick();
      m_if.bvalid = 1'b0; s_if.bready = 1'b0;
      settle();
      chk("cc_b_done", s_if.bvalid, 0);

      // Reset asserted in the middle of a drained write.
      s_if.awaddr = 64'h2000; s_if.awlen = 8'd3; s_if.awsize = 3'd4; s_if.awid = 4'h6; s_if.awvalid = 1'b1;
      tick();
      s_if.awvalid = 1'b0;
      s_if.wvalid = 1'b1; s_if.wlast = 1'b0;
      settle();
      chk("rd_drain_wready", s_if.wready, 1);
      tick();
      rst = 1'b1;
      settle();
      chk_all_quiet("rd_reset");
      exp_rd_err = 0;
      exp_wr_err = 0;
      chk_cnt();
      s_if.wvalid = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      chk("rd_no_stale_b", s_if.bvalid, 0);
      do_write(BASE + 64'h40, 2, 4, 4'h9, 1);
      chk_cnt();

      // Randomized mix of reads and writes around the window boundaries.
      for (int i = 0; i < 30; i++) begin
         cat  = $urandom_range(0, 3);
         len  = $urandom_range(0, 7);
         size = $urandom_range(0, 4);
         id   = 4'($urandom);
         case (cat)
            0:       addr = BASE + 64'($urandom_range(0, 32'h3FFF_0000) & 32'hFFFF_FFC0);
            1:       addr = BASE - 64'($urandom_range(1, 4096));
            2:       addr = BASE + SIZE - 64'($urandom_range(1, 8192));
            default: addr = {$urandom, $urandom};
         endcase
         if ($urandom_range(0, 1) == 1) do_read(addr, len, size, id, $urandom_range(0, 2));
         else                           do_write(addr, len, size, id, $urandom_range(0, 2));
         chk_cnt();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/bp_axi_mem_window.md
BP_AXI_MEM_WINDOW -- requirements
Module: bp_axi_mem_window

Interface
REQ-001 The block SHALL sit between the BlackParrot m01 memory AXI4 manager (slave side, s_axi_*) and the DRAM controller (master side, m_axi_*).
REQ-002 Parameter ADDR_WIDTH_P, default 64, SHALL set the AXI address width.
REQ-003 Parameter DATA_WIDTH_P, default 128, SHALL set the AXI data width; strobe width is DATA_WIDTH_P/8.
REQ-004 Parameter ID_WIDTH_P, default 4, SHALL set the AXI ID width.
REQ-005 Parameter BASE_ADDR_P, default 64'h8000_0000, SHALL set the DRAM window base.
REQ-006 Parameter SIZE_P, default 64'h4000_0000, SHALL set the window size in bytes.
REQ-007 Port clk_i, input, 1: the single clock.
REQ-008 Port reset_i, input, 1: asynchronous, active-high reset.
REQ-009 Ports s_axi_aw*_i / s_axi_awready_o SHALL carry a full AW channel: addr, id, len 8, size 3, burst 2, lock, cache 4, prot 3, qos 4, region 4, valid.
REQ-010 Ports s_axi_w*_i / s_axi_wready_o SHALL carry the W channel: data, strb, last, valid.
REQ-011 Ports s_axi_b*_o / s_axi_bready_i SHALL carry the B channel: id, resp 2, valid.
REQ-012 Ports s_axi_ar*_i / s_axi_arready_o SHALL carry an AR channel with the same fields as AW.
REQ-013 Ports s_axi_r*_o / s_axi_rready_i SHALL carry the R channel: data, id, resp 2, last, valid.
REQ-014 The m_axi_* ports SHALL mirror REQ-009..013 with the directions reversed.

Function
REQ-015 A request SHALL be in-window iff addr >= BASE_ADDR_P and last_byte = addr + ((len+1)<<size) - 1 <= BASE_ADDR_P+SIZE_P-1, computed at ADDR_WIDTH_P+9 bits so that no wrap occurs.
REQ-016 For an in-window request, m_axi_*addr SHALL equal addr - BASE_ADDR_P; all other AW/AR fields SHALL pass through unchanged.
REQ-017 The write FSM SHALL have states W_IDLE, W_PASS, W_DRAIN, W_BPASS, W_BERR.
- Only one write is outstanding.
- In W_IDLE, an in-window AW SHALL connect combinationally to m_axi (zero latency); the AW handshake moves the FSM to W_PASS.
- In W_IDLE, an out-of-window AW SHALL be accepted with awready=1, SHALL never reach m_axi, its id SHALL be captured, and the FSM SHALL move to W_DRAIN.
REQ-018 W_PASS SHALL forward W beats combinationally; the wlast handshake moves the FSM to W_BPASS, which forwards B and returns to W_IDLE on the B handshake.
REQ-019 W_DRAIN SHALL hold s_axi_wready=1 and m_axi_wvalid=0, and SHALL discard beats until wlast.
- It then moves to W_BERR, which drives s_axi_bvalid=1, bresp=2'b11 (DECERR) and the captured id.
- It holds until bready, then returns to W_IDLE.
REQ-020 The read FSM SHALL have states R_IDLE, R_PASS, R_ERR, with one read outstanding.
- In R_IDLE, in-window AR SHALL pass combinationally; the handshake moves the FSM to R_PASS.
- R_PASS forwards R until the rlast handshake.
- Out-of-window AR SHALL be accepted and move the FSM to R_ERR, which generates len+1 beats with rdata=0, rresp=DECERR, the captured id, and rlast on the final beat; a beat advances only on rready.
REQ-021 Outside the states named in REQ-017..020, the corresponding valid/ready outputs SHALL be 0. The read and write paths SHALL be fully independent, and simultaneous AR and AW acceptance SHALL be legal.
REQ-022 A beat counter SHALL be 8 bits; len=255 SHALL produce 256 error beats.

Reset
REQ-023 On reset_i=1, both FSMs SHALL go to IDLE asynchronously and all valid/ready outputs SHALL be 0 on the next evaluation. Captured id, len and counters SHALL be cleared.
REQ-024 Reset asserted mid-burst SHALL abort the burst with no further beats emitted; recovery is the system's responsibility.

Configuration
REQ-025 With macro AXI_MEM_WINDOW_ERR_CNT_EN defined, the block SHALL add err_rd_cnt_o and err_wr_cnt_o (outputs, 16 bits each).
- Each counter SHALL increment by 1 on every out-of-window AR/AW acceptance.
- Each counter SHALL saturate at 16'hFFFF.
- Each counter SHALL reset to 0.
REQ-026 Without AXI_MEM_WINDOW_ERR_CNT_EN, those ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-027 AR addr=0x8000_0040, len=3, size=4 -> m_axi_araddr=0x40 in the same cycle; 4 R beats forwarded, rlast on the 4th.
REQ-028 AW addr=0x1000, len=1 -> no m_axi_awvalid; 2 W beats drained; B with resp=2'b11 and matching id; err_wr_cnt_o=1 with the macro defined.
REQ-029 AR addr=0xBFFF_FFF0, len=1, size=4 (straddles the window end) -> 2 DECERR beats of rdata=0, rlast on beat 2.
REQ-030 rready held low for 5 cycles during an R_ERR burst -> beat index and rvalid held; no beat lost or duplicated.
REQ-031 Concurrent in-window AW and AR in the same cycle -> both handshake and both complete independently.
REQ-032 reset_i pulsed mid W_DRAIN -> all valids 0 immediately, FSM in W_IDLE, and a fresh in-window write completes normally.
